// File: rtl/fcs_checker_if.sv
// Bundles the PSDU byte stream and frame controls seen by fcs_checker with its result and payload outputs.
// The master modport is the upstream receive chain; the slave modport is the checker.
interface fcs_checker_if #(
    parameter int LEN_WIDTH = 12
);
    logic                 enable;
    logic                 pkt_begin;
    logic [LEN_WIDTH-1:0] pkt_len;
    logic [7:0]           byte_in;
    logic                 byte_in_strobe;
    logic                 busy;
    logic [LEN_WIDTH-1:0] byte_count;
    logic                 fcs_out_strobe;
    logic                 fcs_ok;
    logic [7:0]           payload_out;
    logic                 payload_out_strobe;

    modport master (
        output enable, pkt_begin, pkt_len, byte_in, byte_in_strobe,
        input  busy, byte_count, fcs_out_strobe, fcs_ok, payload_out, payload_out_strobe
    );

    modport slave (
        input  enable, pkt_begin, pkt_len, byte_in, byte_in_strobe,
        output busy, byte_count, fcs_out_strobe, fcs_ok, payload_out, payload_out_strobe
    );
endinterface

// File: rtl/fcs_checker.sv
// CRC-32 FCS check over a length-framed PSDU stream; optional FCS-stripped payload via FCS_PAYLOAD_PASSTHRU_EN.
// Latency: fcs_out_strobe the cycle after the last byte is accepted; payload bytes 1 cycle after being shifted out.
// No backpressure: bytes are taken whenever strobed; enable=0 freezes all state while strobes still self-clear.
module fcs_checker #(
    parameter int          LEN_WIDTH = 12,
    parameter int          MIN_LEN   = 4,
    parameter logic [31:0] RESIDUE   = 32'hDEBB20E3
) (
    input logic           clock,
    input logic           reset,
    fcs_checker_if.slave  bus
);
    localparam logic [0:0]           S_IDLE    = 1'b0;
    localparam logic [0:0]           S_DATA    = 1'b1;
    localparam logic [31:0]          POLY      = 32'hEDB88320;
    localparam logic [LEN_WIDTH-1:0] MIN_LEN_L = LEN_WIDTH'(MIN_LEN);

    logic [0:0]           state;
    logic [31:0]          crc;
    logic [31:0]          crc_next;
    logic [LEN_WIDTH-1:0] len;
    logic [LEN_WIDTH-1:0] count;
    logic [LEN_WIDTH-1:0] count_inc;
    logic                 ok;
    logic                 strobe;
    logic                 start;
    logic                 accept;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
        end
        return r;
    endfunction

    // pkt_begin takes priority over a byte strobed in the same cycle
    assign start     = bus.enable && bus.pkt_begin;
    assign accept    = bus.enable && !bus.pkt_begin && bus.byte_in_strobe && (state == S_DATA);
    assign crc_next  = crc_byte(crc, bus.byte_in);
    assign count_inc = count + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= S_IDLE;
            crc    <= 32'hFFFFFFFF;
            len    <= '0;
            count  <= '0;
            ok     <= 1'b0;
            strobe <= 1'b0;
        end else begin
            strobe <= 1'b0;
            if (start) begin
                count <= '0;
                ok    <= 1'b0;
                crc   <= 32'hFFFFFFFF;
                if (bus.pkt_len >= MIN_LEN_L) begin
                    state <= S_DATA;
                    len   <= bus.pkt_len;
                end else begin
                    state  <= S_IDLE;
                    strobe <= 1'b1;
                end
            end else if (accept) begin
                crc   <= crc_next;
                count <= count_inc;
                if (count_inc == len) begin
                    ok     <= (crc_next == RESIDUE);
                    strobe <= 1'b1;
                    state  <= S_IDLE;
                end
            end
        end
    end

    assign bus.busy           = (state == S_DATA);
    assign bus.byte_count     = count;
    assign bus.fcs_ok         = ok;
    assign bus.fcs_out_strobe = strobe;

`ifdef FCS_PAYLOAD_PASSTHRU_EN
    localparam logic [LEN_WIDTH-1:0] FCS_BYTES = LEN_WIDTH'(4);

    // dline[3] is the oldest byte; the last four bytes of a frame (the FCS) never leave it
    logic [3:0][7:0] dline;
    logic [7:0]      pay;
    logic            pay_stb;

    always_ff @(posedge clock) begin
        if (reset) begin
            dline   <= '0;
            pay     <= 8'd0;
            pay_stb <= 1'b0;
        end else begin
            pay_stb <= 1'b0;
            if (start) begin
                dline <= '0;
            end else if (accept) begin
                dline <= {dline[2:0], bus.byte_in};
                if (count >= FCS_BYTES) begin
                    pay     <= dline[3];
                    pay_stb <= 1'b1;
                end
            end
        end
    end

    assign bus.payload_out        = pay;
    assign bus.payload_out_strobe = pay_stb;
`else
    assign bus.payload_out        = 8'd0;
    assign bus.payload_out_strobe = 1'b0;
`endif
endmodule

// File: tb/tb_fcs_checker.sv
// Self-checking bench for fcs_checker: vector table, hand-written corner sequences, random frames vs a CRC model.
// Latency: n/a. Backpressure: n/a (bench drives the stream freely).
// Payload expectations are checked when FCS_PAYLOAD_PASSTHRU_EN is defined.
module tb_fcs_checker;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    fcs_checker_if #(.LEN_WIDTH(12)) bus ();
    fcs_checker #(.LEN_WIDTH(12)) dut (.clock(clock), .reset(reset), .bus(bus));

    typedef struct {
        int           len;
        int           n;
        logic [127:0] b;
        logic         ok;
        int           cnt;
    } vec_t;

    int         total = 0;
    int         passed = 0;
    int         strobe_cnt = 0;
    logic       last_ok = 1'b0;
    logic [7:0] pay_q[$];
    logic [7:0] frm[$];
    vec_t       vt[7];

    always @(negedge clock) begin
        if (bus.fcs_out_strobe) begin
            strobe_cnt++;
            last_ok = bus.fcs_ok;
        end
        if (bus.payload_out_strobe) pay_q.push_back(bus.payload_out);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic begin_pkt(input int len);
        bus.pkt_begin = 1'b1;
        bus.pkt_len   = 12'(len);
        tick();
        bus.pkt_begin = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.byte_in        = b;
        bus.byte_in_strobe = 1'b1;
        tick();
        bus.byte_in_strobe = 1'b0;
        idle(gap);
    endtask

    // Sends frm; optionally inserts enable-low windows carrying stray strobes that must be ignored
    task automatic send_frame(input int gap_max, input bit drops);
        for (int i = 0; i < frm.size(); i++) begin
            if (drops && $urandom_range(0, 5) == 0) begin
                bus.enable         = 1'b0;
                bus.byte_in        = 8'($urandom);
                bus.byte_in_strobe = 1'b1;
                idle($urandom_range(1, 4));
                bus.byte_in_strobe = 1'b0;
                bus.enable         = 1'b1;
            end
            send_byte(frm[i], $urandom_range(0, gap_max));
        end
    endtask

    function automatic logic [31:0] crc_of(input int n);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < 8; j++)
                c = (c[0] ^ frm[i][j]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return ~c;
    endfunction

    task automatic load_test1();
        logic [127:0] t;
        t = 128'h31323334353637383926_39F4CB000000;
        frm.delete();
        for (int i = 0; i < 13; i++) frm.push_back(t[(15-i)*8 +: 8]);
    endtask

    // Expected payload: the first n_acc-4 accepted bytes, nothing from the FCS
    task automatic check_payload(input string name, input int n_acc);
`ifdef FCS_PAYLOAD_PASSTHRU_EN
        int exp_n;
        int bad;
        exp_n = (n_acc > 4) ? n_acc - 4 : 0;
        check({name, " pay_n"}, pay_q.size(), exp_n);
        bad = 0;
        for (int i = 0; i < exp_n && i < pay_q.size(); i++)
            if (pay_q[i] !== frm[i]) bad++;
        check({name, " pay_dat"}, bad, 0);
`else
        check({name, " pay_none"}, pay_q.size() + n_acc * 0, 0);
`endif
    endtask

    initial begin
        vt[0] = '{13, 13, 128'h31323334353637383926_39F4CB000000, 1'b1, 13};
        vt[1] = '{13, 13, 128'h31323334343637383926_39F4CB000000, 1'b0, 13};
        vt[2] = '{2,  2,  128'hAABB0000_00000000_00000000_00000000, 1'b0, 0};
        vt[3] = '{4,  4,  128'h0, 1'b1, 4};
        vt[4] = '{3,  3,  128'h01020300_00000000_00000000_00000000, 1'b0, 0};
        vt[5] = '{13, 16, 128'h31323334353637383926_39F4CB_DEADBE, 1'b1, 13};
        vt[6] = '{0,  2,  128'h11220000_00000000_00000000_00000000, 1'b0, 0};

        reset = 1'b1;
        bus.enable = 1'b1;
        bus.pkt_begin = 1'b0;
        bus.pkt_len = '0;
        bus.byte_in = '0;
        bus.byte_in_strobe = 1'b0;
        idle(3);
        @(negedge clock);
        check("rst busy", bus.busy, 0);
        check("rst cnt", bus.byte_count, 0);
        check("rst ok", bus.fcs_ok, 0);
        check("rst stb", bus.fcs_out_strobe, 0);
        check("rst pay", {bus.payload_out_strobe, bus.payload_out}, 0);
        reset = 1'b0;
        idle(2);

        for (int k = 0; k < 7; k++) begin
            int n_acc;
            frm.delete();
            for (int i = 0; i < vt[k].n; i++) frm.push_back(vt[k].b[(15-i)*8 +: 8]);
            strobe_cnt = 0;
            pay_q.delete();
            begin_pkt(vt[k].len);
            send_frame(0, 0);
            idle(3);
            check($sformatf("v%0d strobes", k), strobe_cnt, 1);
            check($sformatf("v%0d ok", k), last_ok, vt[k].ok);
            check($sformatf("v%0d cnt", k), bus.byte_count, vt[k].cnt);
            check($sformatf("v%0d busy", k), bus.busy, 0);
            n_acc = (vt[k].len >= 4) ? ((vt[k].n < vt[k].len) ? vt[k].n : vt[k].len) : 0;
            check_payload($sformatf("v%0d", k), n_acc);
        end

        // Short frame: strobe exactly the next cycle, never busy
        begin_pkt(2);
        @(negedge clock);
        check("short stb", bus.fcs_out_strobe, 1);
        check("short ok", bus.fcs_ok, 0);
        check("short busy", bus.busy, 0);
        @(negedge clock);
        check("short stb_clr", bus.fcs_out_strobe, 0);

        // Abort after 6 bytes, then a full valid frame; also exact completion latency
        load_test1();
        strobe_cnt = 0;
        begin_pkt(13);
        for (int i = 0; i < 6; i++) send_byte(frm[i], 0);
        begin_pkt(13);
        pay_q.delete();
        @(negedge clock);
        check("abort busy", bus.busy, 1);
        for (int i = 0; i < 13; i++) send_byte(frm[i], 0);
        @(negedge clock);
        check("abort lat stb", bus.fcs_out_strobe, 1);
        @(negedge clock);
        check("abort lat clr", bus.fcs_out_strobe, 0);
        idle(2);
        check("abort strobes", strobe_cnt, 1);
        check("abort ok", last_ok, 1);
        check_payload("abort", 13);

        // pkt_begin and a byte in the same cycle: the byte is dropped
        strobe_cnt = 0;
        begin_pkt(13);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        bus.byte_in = 8'hAA;
        bus.byte_in_strobe = 1'b1;
        begin_pkt(13);
        bus.byte_in_strobe = 1'b0;
        check("same cnt", bus.byte_count, 0);
        for (int i = 0; i < 13; i++) send_byte(frm[i], 0);
        idle(2);
        check("same strobes", strobe_cnt, 1);
        check("same ok", last_ok, 1);
        check("same cnt13", bus.byte_count, 13);

        // Slow stream with a 20-cycle enable drop, stray strobes and pkt_begin while frozen
        strobe_cnt = 0;
        pay_q.delete();
        begin_pkt(13);
        for (int i = 0; i < 13; i++) begin
            send_byte(frm[i], (i == 12) ? 0 : 4);
            if (i == 5) begin
                bus.enable = 1'b0;
                for (int c = 0; c < 20; c++) begin
                    bus.byte_in_strobe = (c % 3 == 0);
                    bus.byte_in = 8'(c);
                    bus.pkt_begin = (c == 10);
                    bus.pkt_len = 12'd2;
                    tick();
                end
                bus.byte_in_strobe = 1'b0;
                bus.pkt_begin = 1'b0;
                check("frz cnt", bus.byte_count, 6);
                check("frz busy", bus.busy, 1);
                check("frz strobes", strobe_cnt, 0);
                bus.enable = 1'b1;
            end
        end
        bus.enable = 1'b0;
        @(negedge clock);
        check("frz stb", bus.fcs_out_strobe, 1);
        @(negedge clock);
        check("frz stb_clr", bus.fcs_out_strobe, 0);
        tick();
        bus.enable = 1'b1;
        for (int i = 0; i < 3; i++) send_byte(8'hC0 + 8'(i), 4);
        idle(2);
        check("slow strobes", strobe_cnt, 1);
        check("slow ok", last_ok, 1);
        check("slow cnt", bus.byte_count, 13);
        check_payload("slow", 13);

        // Reset mid-frame: back to idle, outputs cleared, remaining bytes ignored
        strobe_cnt = 0;
        begin_pkt(13);
        for (int i = 0; i < 5; i++) send_byte(frm[i], 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("mrst busy", bus.busy, 0);
        check("mrst cnt", bus.byte_count, 0);
        check("mrst ok", bus.fcs_ok, 0);
        for (int i = 5; i < 13; i++) send_byte(frm[i], 0);
        idle(2);
        check("mrst strobes", strobe_cnt, 0);
        check("mrst cnt2", bus.byte_count, 0);

        // Random frames against the model: FCS field must equal the CRC of the payload
        for (int r = 0; r < 40; r++) begin
            int          p;
            logic [31:0] fcs;
            logic [31:0] rx_fcs;
            logic        exp_ok;
            p = $urandom_range(0, 12);
            frm.delete();
            for (int i = 0; i < p; i++) frm.push_back(8'($urandom));
            fcs = crc_of(p);
            for (int i = 0; i < 4; i++) frm.push_back(fcs[i*8 +: 8]);
            if ($urandom_range(0, 1) == 1) begin
                int idx;
                idx = $urandom_range(0, p + 3);
                frm[idx] = frm[idx] ^ (8'd1 << $urandom_range(0, 7));
            end
            rx_fcs = {frm[p+3], frm[p+2], frm[p+1], frm[p]};
            exp_ok = (rx_fcs == crc_of(p));
            strobe_cnt = 0;
            pay_q.delete();
            begin_pkt(p + 4);
            send_frame(2, 1);
            idle(3);
            check($sformatf("r%0d strobes", r), strobe_cnt, 1);
            check($sformatf("r%0d ok", r), last_ok, exp_ok);
            check($sformatf("r%0d cnt", r), bus.byte_count, p + 4);
            check_payload($sformatf("r%0d", r), p + 4);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
